// File: rtl/word_overlay_pkg.sv
// word_overlay_pkg
//   Shared defaults and types for the word overlay scheduler.
//   - NSLOT_DEF / WORD_W_DEF / WORD_H_DEF : default slot count, bitmap width, bitmap height
//   - COORD_W                            : screen coordinate width
//   - ovl_state_e                        : fetch sequencer states
//   - coord_diff()                       : coordinate difference with borrow kept
package word_overlay_pkg;

   localparam int NSLOT_DEF  = 4;
   localparam int WORD_W_DEF = 64;
   localparam int WORD_H_DEF = 32;
   localparam int COORD_W    = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_LOAD   = 2'd2,
      ST_COMMIT = 2'd3
   } ovl_state_e;

   // a - b one bit wider than the coordinates. When b > a the borrow lands in
   // the top bit, so the result is >= 2**COORD_W and can never pass a
   // "distance < bitmap size" test. This keeps a slot that starts beyond the
   // current coordinate from wrapping round and lighting near column/row 0.
   function automatic logic [COORD_W:0] coord_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

endpackage

// File: rtl/word_overlay_hit.sv
// word_overlay_hit
//   Per-slot pixel test: is the current column inside this slot's bitmap row,
//   and is that bitmap bit set?
//   Ports:
//     pixel_x : current active-video column
//     slot_x  : slot left column
//     hit     : slot has a valid row for the displayed line
//     row     : committed bitmap row, bit 0 = leftmost pixel
//     lit     : slot lights this pixel (combinational)
module word_overlay_hit
   import word_overlay_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] slot_x,
   input  logic               hit,
   input  logic [WORD_W-1:0]  row,
   output logic               lit
);

   localparam int               IDX_W = $clog2(WORD_W);
   localparam logic [COORD_W:0] LIMIT = (COORD_W + 1)'(WORD_W);

   logic [COORD_W:0] dx;

   assign dx  = coord_diff(pixel_x, slot_x);
   assign lit = hit && (dx < LIMIT) && row[dx[IDX_W-1:0]];

endmodule

// File: rtl/word_overlay_sched.sv
// word_overlay_sched
//   Fetches one bitmap row per overlay slot during horizontal blank through a
//   single shared ROM port, then swaps all rows into the display buffers at
//   once so a displayed line never mixes rows from two different lines.
//   Fixed schedule: ADDR + LOAD per slot, then one COMMIT cycle.
//   Ports:
//     clk, reset           : clock, synchronous active-high reset
//     line_start, next_y   : blank-time pulse and the line to fetch for
//     pixel_x, video_on    : active-video column and enable
//     slot_en/x/y/word     : packed per-slot configuration (slot i at i*width)
//     rom_sel, rom_addr    : registered word select / row address to the ROM
//     rom_data             : combinational ROM row, bit 0 = leftmost pixel
//     busy                 : fetch sequence in progress
//     pix_on, pix_slot     : registered overlay pixel and lowest owning slot
module word_overlay_sched
   import word_overlay_pkg::*;
#(
   parameter int NSLOT  = NSLOT_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int WORD_H = WORD_H_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   line_start,
   input  logic [9:0]             next_y,
   input  logic [9:0]             pixel_x,
   input  logic                   video_on,
   input  logic [NSLOT-1:0]       slot_en,
   input  logic [10*NSLOT-1:0]    slot_x,
   input  logic [10*NSLOT-1:0]    slot_y,
   input  logic [2*NSLOT-1:0]     slot_word,
   output logic [1:0]             rom_sel,
   output logic [4:0]             rom_addr,
   input  logic [WORD_W-1:0]      rom_data,
   output logic                   busy,
   output logic                   pix_on,
   output logic [1:0]             pix_slot
);

   localparam int                SLOT_W    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);
   localparam logic [COORD_W:0]  H_LIMIT   = (COORD_W + 1)'(WORD_H);

   // Unpacked views of the packed slot configuration.
   logic [COORD_W-1:0] sx [NSLOT];
   logic [COORD_W-1:0] sy [NSLOT];
   logic [1:0]         sw [NSLOT];

   for (genvar g = 0; g < NSLOT; g++) begin : g_unpack
      assign sx[g] = slot_x[10*g +: 10];
      assign sy[g] = slot_y[10*g +: 10];
      assign sw[g] = slot_word[2*g +: 2];
   end

   // ---------------------------------------------------------------------------
   // Fetch sequencer
   // ---------------------------------------------------------------------------
   ovl_state_e        state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic              addr_phase;
   logic              load_phase;
   logic              commit_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
      end
   end

   // line_start wins in every state: from IDLE it starts a fetch, otherwise it
   // aborts the current one. Because it bypasses the case statement, an abort
   // landing on the COMMIT cycle suppresses the commit.
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      addr_phase = (state_q == ST_ADDR);
      load_phase = (state_q == ST_LOAD);
      commit_en  = 1'b0;
      if (line_start) begin
         state_d = ST_ADDR;
         slot_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_ADDR: state_d = ST_LOAD;
            ST_LOAD: begin
               if (slot_q == LAST_SLOT) begin
                  state_d = ST_COMMIT;
               end else begin
                  state_d = ST_ADDR;
                  slot_d  = slot_q + 1'b1;
               end
            end
            ST_COMMIT: begin
               state_d   = ST_IDLE;
               commit_en = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
      end else begin
         busy <= (state_d != ST_IDLE);
      end
   end

   // ---------------------------------------------------------------------------
   // ROM addressing (ADDR) and shadow capture (LOAD)
   // ---------------------------------------------------------------------------
   logic [COORD_W:0] dy_c;
   logic [COORD_W:0] dy_q;

   assign dy_c = coord_diff(next_y, sy[slot_q]);

   always_ff @(posedge clk) begin
      if (reset) begin
         rom_sel  <= 2'd0;
         rom_addr <= 5'd0;
         dy_q     <= '0;
      end else if (addr_phase) begin
         rom_sel  <= sw[slot_q];
         rom_addr <= dy_c[4:0];
         dy_q     <= dy_c;
      end
   end

   logic [NSLOT-1:0]  shadow_hit;
   logic [WORD_W-1:0] shadow_row [NSLOT];
   logic [NSLOT-1:0]  active_hit;
   logic [WORD_W-1:0] active_row [NSLOT];

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_hit <= '0;
      end else if (load_phase) begin
         shadow_hit[slot_q] <= slot_en[slot_q] && (dy_q < H_LIMIT);
      end
   end

   // Row data carries no reset: a row is only ever looked at through its hit flag.
   always_ff @(posedge clk) begin
      if (load_phase) begin
         shadow_row[slot_q] <= rom_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_hit <= '0;
      end else if (commit_en) begin
         active_hit <= shadow_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (commit_en) begin
         active_row <= shadow_row;
      end
   end

   // ---------------------------------------------------------------------------
   // Pixel path
   // ---------------------------------------------------------------------------
   logic [NSLOT-1:0] lit;
   logic [1:0]       low_idx;

   for (genvar g = 0; g < NSLOT; g++) begin : g_hit
      word_overlay_hit #(
         .WORD_W (WORD_W)
      ) u_hit (
         .pixel_x (pixel_x),
         .slot_x  (sx[g]),
         .hit     (active_hit[g]),
         .row     (active_row[g]),
         .lit     (lit[g])
      );
   end

   // Walk from the top so the last assignment is the lowest lit slot.
   always_comb begin
      low_idx = 2'd0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (lit[i]) begin
            low_idx = i[1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_on   <= 1'b0;
         pix_slot <= 2'd0;
      end else begin
         pix_on   <= video_on && (|lit);
         pix_slot <= (video_on && (|lit)) ? low_idx : 2'd0;
      end
   end

endmodule

// File: tb/tb_word_overlay_sched.sv
// tb_word_overlay_sched
//   Directed bench for word_overlay_sched. A line-level model (committed
//   rows/hits per slot, fetch age counter) predicts busy/pix_on/pix_slot
//   every cycle; literal checks pin key values at known cycles.
module tb_word_overlay_sched;

   localparam int NSLOT  = 4;
   localparam int WORD_W = 64;
   localparam int WORD_H = 32;
   localparam int FETCH  = 2 * NSLOT + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [9:0]  next_y;
   logic [9:0]  pixel_x;
   logic        video_on;
   logic [3:0]  slot_en;
   logic [39:0] slot_x;
   logic [39:0] slot_y;
   logic [7:0]  slot_word;
   logic [1:0]  rom_sel;
   logic [4:0]  rom_addr;
   logic [63:0] rom_data;
   logic        busy;
   logic        pix_on;
   logic [1:0]  pix_slot;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- ROM ----------------
   logic [63:0] rom_mem [4][32];

   initial begin
      for (int r = 0; r < 32; r++) begin
         rom_mem[0][r] = 64'hFFFF_0000_FFFF_0000 ^ 64'(r);
         rom_mem[1][r] = '1;
         rom_mem[2][r] = 64'h5555_5555_5555_5555;
         rom_mem[3][r] = 64'h8000_0000_0000_0001;
      end
      rom_mem[0][0] = 64'h7FFF_FFE0_4000_0002;
   end

   assign rom_data = rom_mem[rom_sel][rom_addr];

   word_overlay_sched #(
      .NSLOT  (NSLOT),
      .WORD_W (WORD_W),
      .WORD_H (WORD_H)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .next_y     (next_y),
      .pixel_x    (pixel_x),
      .video_on   (video_on),
      .slot_en    (slot_en),
      .slot_x     (slot_x),
      .slot_y     (slot_y),
      .slot_word  (slot_word),
      .rom_sel    (rom_sel),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .busy       (busy),
      .pix_on     (pix_on),
      .pix_slot   (pix_slot)
   );

   // ---------------- model ----------------
   bit          m_pending;
   int          m_age;
   bit          m_hit [NSLOT];
   logic [63:0] m_row [NSLOT];
   logic        e_on;
   logic [1:0]  e_slot;
   logic [3:0]  exp_q [$];

   function automatic bit model_lit(input int i, input logic [9:0] px);
      int dx;
      dx = int'(px) - int'(slot_x[10*i +: 10]);
      return m_hit[i] && (dx >= 0) && (dx < WORD_W) && (m_row[i][dx] == 1'b1);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_pending = 1'b0;
         m_age     = 0;
         for (int i = 0; i < NSLOT; i++) m_hit[i] = 1'b0;
         e_on   = 1'b0;
         e_slot = 2'd0;
      end else begin
         // pixel decision uses the buffers as they were before this edge
         e_on   = 1'b0;
         e_slot = 2'd0;
         if (video_on) begin
            for (int i = 0; i < NSLOT; i++) begin
               if (!e_on && model_lit(i, pixel_x)) begin
                  e_on   = 1'b1;
                  e_slot = 2'(i);
               end
            end
         end
         if (line_start) begin
            m_pending = 1'b1;
            m_age     = 1;
         end else if (m_pending) begin
            m_age++;
            if (m_age == FETCH) begin
               for (int i = 0; i < NSLOT; i++) begin
                  int dy;
                  dy = int'(next_y) - int'(slot_y[10*i +: 10]);
                  m_hit[i] = slot_en[i] && (dy >= 0) && (dy < WORD_H);
                  m_row[i] = rom_mem[slot_word[2*i +: 2]][dy & 31];
               end
               m_pending = 1'b0;
            end
         end
      end
      if (chk_en) exp_q.push_back({m_pending, e_on, e_slot});
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [3:0] exp_v;
      logic [3:0] act_v;
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         act_v = {busy, pix_on, pix_slot};
         n_checks++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t busy/pix_on/pix_slot got %b expected %b",
                     $time, act_v, exp_v);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_slot(input int i, input bit en, input int x, input int y, input int w);
      slot_en[i]         = en;
      slot_x[10*i +: 10] = 10'(x);
      slot_y[10*i +: 10] = 10'(y);
      slot_word[2*i +: 2] = 2'(w);
   endtask

   // returns at cycle 1 of the fetch (one edge after line_start was sampled)
   task automatic pulse_line(input int y);
      next_y     = 10'(y);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic pix_at(input int x);
      pixel_x = 10'(x);
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      line_start = 1'b0;
      next_y     = '0;
      pixel_x    = '0;
      video_on   = 1'b0;
      slot_en    = '0;
      slot_x     = '0;
      slot_y     = '0;
      slot_word  = '0;
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_pix_on", 64'(pix_on), 64'd0);
      check("rst_pix_slot", 64'(pix_slot), 64'd0);
      check("rst_rom_sel", 64'(rom_sel), 64'd0);
      check("rst_rom_addr", 64'(rom_addr), 64'd0);

      // single slot, row 0
      set_slot(0, 1, 100, 50, 0);
      pulse_line(50);
      check("s1_busy_c1", 64'(busy), 64'd1);
      run(8);
      check("s1_busy_c9", 64'(busy), 64'd1);
      run(1);
      check("s1_busy_c10", 64'(busy), 64'd0);
      check("s1_model_hit0", 64'(m_hit[0]), 64'd1);
      video_on = 1'b1;
      pix_at(101); check("s1_px101_on", 64'(pix_on), 64'd1);
      check("s1_px101_slot", 64'(pix_slot), 64'd0);
      pix_at(100); check("s1_px100_on", 64'(pix_on), 64'd0);
      pix_at(138); check("s1_px138_on", 64'(pix_on), 64'd1);
      pix_at(132); check("s1_px132_on", 64'(pix_on), 64'd0);
      pix_at(130); check("s1_px130_on", 64'(pix_on), 64'd1);
      for (int x = 90; x < 175; x++) pix_at(x);
      video_on = 1'b0;

      // last row (dy = 31) hits, dy = 32 does not
      pulse_line(81);
      tick();
      check("s2_rom_addr", 64'(rom_addr), 64'd31);
      check("s2_rom_sel", 64'(rom_sel), 64'd0);
      run(8);
      video_on = 1'b1;
      pix_at(100); check("s2_dy31_px100", 64'(pix_on), 64'd1);
      pix_at(105); check("s2_dy31_px105", 64'(pix_on), 64'd0);
      video_on = 1'b0;
      pulse_line(82);
      run(9);
      check("s2_model_hit0", 64'(m_hit[0]), 64'd0);
      video_on = 1'b1;
      pix_at(100); check("s2_dy32_px100", 64'(pix_on), 64'd0);
      for (int x = 90; x < 180; x++) pix_at(x);
      video_on = 1'b0;

      // overlap priority
      set_slot(0, 1, 200, 10, 1);
      set_slot(2, 1, 180, 10, 1);
      pulse_line(10);
      run(9);
      video_on = 1'b1;
      pix_at(200); check("s3_both_on", 64'(pix_on), 64'd1);
      check("s3_both_slot", 64'(pix_slot), 64'd0);
      pix_at(190); check("s3_only2_slot", 64'(pix_slot), 64'd2);
      slot_en[0] = 1'b0;
      pulse_line(10);
      run(9);
      pix_at(200); check("s3_dis0_slot", 64'(pix_slot), 64'd2);

      // abort and restart: old buffers stay until the restarted commit
      slot_en[0] = 1'b1;
      pulse_line(10);
      run(3);
      pulse_line(10);
      check("s4_busy_c1", 64'(busy), 64'd1);
      run(8);
      check("s4_busy_c9", 64'(busy), 64'd1);
      check("s4_old_slot_c9", 64'(pix_slot), 64'd2);
      tick();
      check("s4_busy_c10", 64'(busy), 64'd0);
      check("s4_old_slot_c10", 64'(pix_slot), 64'd2);
      tick();
      check("s4_new_slot_c11", 64'(pix_slot), 64'd0);

      // reset mid-fetch clears hits
      pulse_line(10);
      run(4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("s5_busy", 64'(busy), 64'd0);
      check("s5_pix_on", 64'(pix_on), 64'd0);
      tick();
      check("s5_hits_cleared", 64'(pix_on), 64'd0);
      run(12);
      check("s5_still_dark", 64'(pix_on), 64'd0);
      reset      = 1'b1;
      line_start = 1'b1;
      tick();
      reset      = 1'b0;
      line_start = 1'b0;
      check("s5_rst_vs_ls_busy", 64'(busy), 64'd0);
      tick();
      check("s5_rst_vs_ls_busy2", 64'(busy), 64'd0);
      video_on = 1'b0;

      // wrap-around and video gating
      set_slot(0, 1, 1000, 50, 1);
      set_slot(2, 0, 0, 0, 0);
      pulse_line(50);
      run(9);
      video_on = 1'b1;
      pix_at(5);    check("s6_wrap_x", 64'(pix_on), 64'd0);
      pix_at(1010); check("s6_px1010", 64'(pix_on), 64'd1);
      slot_en[0] = 1'b0;
      pix_at(1011); check("s6_cfg_late", 64'(pix_on), 64'd1);
      video_on = 1'b0;
      tick();       check("s6_video_off", 64'(pix_on), 64'd0);
      set_slot(0, 1, 1000, 1000, 1);
      pulse_line(5);
      run(9);
      video_on = 1'b1;
      pix_at(1010); check("s6_wrap_y", 64'(pix_on), 64'd0);
      video_on = 1'b0;
      run(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
